// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment scan: debounces each digit select,
// decodes segment patterns back to nibbles and publishes complete 16-bit frames.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1 << 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEG,
    output logic [15:0] value,
    output logic [3:0]  points,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        value_changed,
    output logic        stalled
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, LATCHED} state_t;

    state_t        state_q, state_d;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;
    logic [11:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [15:0]   digit_q, digit_d, value_q, value_d;
    logic [3:0]    dp_q, dp_d, points_q, points_d;
    logic [3:0]    seen_q, seen_d;
    logic          err_q, err_d;
    logic          frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
    logic          value_changed_q, value_changed_d, stalled_q, stalled_d;

    logic          changed, onehot, start, accept, complete;
    logic [1:0]    sel;
    logic [4:0]    dec;

    // Returns {decodable, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;  7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        prev_d  = {an_q, seg_q};
        changed = ({an_q, seg_q} != prev_q);
        onehot  = 1'b1;
        sel     = 2'd0;
        case (an_q)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: onehot = 1'b0;
        endcase
        dec     = decode(~seg_q[6:0]);
        cnt_inc = cnt_q + CW'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            WAIT_SEL: start = onehot;
            SETTLE: begin
                if (!changed) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(STABLE_CYCLES)) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = LATCHED;
                    end
                end else if (onehot) begin
                    start = 1'b1;
                end else begin
                    state_d = WAIT_SEL;
                end
            end
            LATCHED: begin
                if (changed) begin
                    if (onehot) start = 1'b1;
                    else        state_d = WAIT_SEL;
                end
            end
            default: state_d = WAIT_SEL;
        endcase
        if (start) begin
            if (STABLE_CYCLES <= 1) begin
                accept  = 1'b1;
                state_d = LATCHED;
            end else begin
                cnt_d   = CW'(1);
                state_d = SETTLE;
            end
        end

        // Completion clears the frame first so an accept in the same cycle seeds the next one.
        complete  = (seen_q == 4'b1111);
        seen_d    = complete ? 4'b0000 : seen_q;
        err_d     = complete ? 1'b0 : err_q;
        digit_d   = digit_q;
        dp_d      = dp_q;
        stalled_d = stalled_q;
        tmo_inc   = tmo_q + TW'(1);
        tmo_d     = tmo_q;

        if (accept) begin
            tmo_d     = '0;
            stalled_d = 1'b0;
            digit_d[{sel, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
            dp_d[sel]   = ~seg_q[7];
            seen_d[sel] = 1'b1;
            if (!dec[4]) err_d = 1'b1;
        end else if (tmo_q != TW'(TIMEOUT)) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TW'(TIMEOUT)) begin
                seen_d    = 4'b0000;
                err_d     = 1'b0;
                stalled_d = 1'b1;
            end
        end

        frame_valid_d   = complete && !err_q;
        frame_err_d     = complete && err_q;
        value_changed_d = frame_valid_d && (digit_q != value_q);
        value_d         = frame_valid_d ? digit_q : value_q;
        points_d        = frame_valid_d ? dp_q : points_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q            <= '1;
            seg_q           <= '1;
            prev_q          <= '1;
            state_q         <= WAIT_SEL;
            cnt_q           <= '0;
            tmo_q           <= '0;
            digit_q         <= '0;
            dp_q            <= '0;
            seen_q          <= '0;
            err_q           <= 1'b0;
            value_q         <= '0;
            points_q        <= '0;
            frame_valid_q   <= 1'b0;
            frame_err_q     <= 1'b0;
            value_changed_q <= 1'b0;
            stalled_q       <= 1'b0;
        end else begin
            an_q            <= AN;
            seg_q           <= SEG;
            prev_q          <= prev_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            digit_q         <= digit_d;
            dp_q            <= dp_d;
            seen_q          <= seen_d;
            err_q           <= err_d;
            value_q         <= value_d;
            points_q        <= points_d;
            frame_valid_q   <= frame_valid_d;
            frame_err_q     <= frame_err_d;
            value_changed_q <= value_changed_d;
            stalled_q       <= stalled_d;
        end
    end

    assign value         = value_q;
    assign points        = points_q;
    assign frame_valid   = frame_valid_q;
    assign frame_err     = frame_err_q;
    assign value_changed = value_changed_q;
    assign stalled       = stalled_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frame pulses are queued as digits are
// scanned and matched against every frame_valid/frame_err pulse the decoder emits.
module tb_seg_scan_decoder;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  AN  = 4'hF;
    logic [7:0]  SEG = 8'hFF;
    logic [15:0] value;
    logic [3:0]  points;
    logic        frame_valid, frame_err, value_changed, stalled;

    typedef struct {
        logic        is_err;
        logic [15:0] value;
        logic [3:0]  points;
        logic        changed;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          pulse_cnt = 0;
    logic [15:0] model_val = '0;
    logic [3:0]  model_pts = '0;

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .AN(AN), .SEG(SEG),
        .value(value), .points(points), .frame_valid(frame_valid),
        .frame_err(frame_err), .value_changed(value_changed), .stalled(stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return {~dp, ~p};
    endfunction

    function automatic logic [3:0] an_of(input int unsigned i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        AN  = an;
        SEG = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic digit(input int unsigned i, input logic [3:0] n, input logic dp, input int cyc);
        hold(an_of(i), seg_of(n, dp), cyc);
    endtask

    task automatic scan_frame(input logic [15:0] v, input logic [3:0] dpm);
        for (int unsigned i = 0; i < 4; i++) digit(i, v[i*4 +: 4], dpm[i], 8);
    endtask

    task automatic push_valid(input logic [15:0] v, input logic [3:0] p);
        exp_t e;
        e.is_err  = 1'b0;
        e.value   = v;
        e.points  = p;
        e.changed = (v != model_val);
        model_val = v;
        model_pts = p;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err  = 1'b1;
        e.value   = model_val;
        e.points  = model_pts;
        e.changed = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err || value_changed)) begin
            pulse_cnt++;
            chk("pulse_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_valid", frame_valid, !e.is_err);
                chk("frame_err", frame_err, e.is_err);
                chk("value", value, e.value);
                chk("points", points, e.points);
                chk("value_changed", value_changed, e.changed);
            end
        end
    end

    initial begin
        int pc;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 0);
        chk("rst_points", points, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_value_changed", value_changed, 0);
        chk("rst_stalled", stalled, 0);
        rst = 1'b0;
        hold(4'hF, 8'hFF, 2);

        // 1: first frame 0x1234
        push_valid(16'h1234, 4'h0);
        scan_frame(16'h1234, 4'h0);
        hold(4'hF, 8'hFF, 2);
        wait_drain("drain_t1");

        // 2: repeated frame, then a changed one
        push_valid(16'h1234, 4'h0);
        scan_frame(16'h1234, 4'h0);
        push_valid(16'h1235, 4'h0);
        scan_frame(16'h1235, 4'h0);
        hold(4'hF, 8'hFF, 2);
        wait_drain("drain_t2");

        // 3: d1 held only 3 cycles then glitched must not be accepted
        pc = pulse_cnt;
        digit(0, 4'h5, 1'b0, 8);
        digit(1, 4'h9, 1'b0, 3);
        hold(an_of(1), 8'h00, 1);
        hold(4'hF, 8'hFF, 2);
        digit(2, 4'h7, 1'b0, 8);
        digit(3, 4'h1, 1'b0, 8);
        hold(4'hF, 8'hFF, 4);
        chk("glitch_no_frame", pulse_cnt, pc);
        push_valid(16'h1795, 4'h0);
        digit(1, 4'h9, 1'b0, 4);
        hold(4'hF, 8'hFF, 4);
        wait_drain("drain_t3");

        // 4: undecodable pattern (g only) on digit2
        push_err();
        digit(0, 4'h4, 1'b0, 8);
        digit(1, 4'h3, 1'b0, 8);
        hold(an_of(2), 8'b1011_1111, 8);
        digit(3, 4'h1, 1'b0, 8);
        hold(4'hF, 8'hFF, 2);
        wait_drain("drain_t4");
        chk("err_value_held", value, 16'h1795);

        // 5: timeout discards a partial frame
        pc = pulse_cnt;
        digit(0, 4'hF, 1'b0, 8);
        digit(1, 4'hF, 1'b0, 8);
        hold(4'hF, 8'hFF, TMO + 10);
        chk("stalled_set", stalled, 1);
        chk("stall_no_pulse", pulse_cnt, pc);
        digit(2, 4'hC, 1'b0, 8);
        chk("stalled_clear", stalled, 0);
        digit(3, 4'h8, 1'b0, 8);
        hold(4'hF, 8'hFF, 4);
        chk("partial_discarded", pulse_cnt, pc);
        push_valid(16'h8C0E, 4'h0);
        digit(0, 4'hE, 1'b0, 8);
        digit(1, 4'h0, 1'b0, 8);
        hold(4'hF, 8'hFF, 2);
        wait_drain("drain_t5");

        // 6: reset lands on the completion edge of a frame
        pc = pulse_cnt;
        digit(0, 4'h8, 1'b0, 8);
        digit(1, 4'h7, 1'b0, 8);
        digit(2, 4'h6, 1'b0, 8);
        digit(3, 4'h5, 1'b0, 5);
        rst = 1'b1;
        hold(4'hF, 8'hFF, 1);
        rst = 1'b0;
        model_val = '0;
        model_pts = '0;
        chk("midrst_value", value, 0);
        chk("midrst_points", points, 0);
        chk("midrst_stalled", stalled, 0);
        chk("midrst_frame_valid", frame_valid, 0);
        hold(4'hF, 8'hFF, 4);
        chk("midrst_no_pulse", pulse_cnt, pc);
        push_valid(16'hABCD, 4'b0010);
        scan_frame(16'hABCD, 4'b0010);
        hold(4'hF, 8'hFF, 2);
        wait_drain("drain_t6");
        chk("final_value", value, 16'hABCD);
        chk("final_points", points, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
